id_stage: RTL

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// Instruction decode stage: field extraction, control decode, condition
// evaluation and a 15-entry register file with write-back bypass.
// Everything except the register file is combinational.
module id_stage #(
  parameter int ADDRESS_LEN     = 32,
  parameter int INSTRUCTION_LEN = 32,
  parameter int REG_COUNT       = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDRESS_LEN-1:0]     PC_in,
  input  logic [INSTRUCTION_LEN-1:0] Instruction,
  input  logic                       hazard,
  input  logic [3:0]                 SR,
  input  logic                       WB_WB_EN,
  input  logic [3:0]                 WB_Dest,
  input  logic [INSTRUCTION_LEN-1:0] WB_Value,
  output logic [ADDRESS_LEN-1:0]     PC,
  output logic                       WB_EN,
  output logic                       MEM_R_EN,
  output logic                       MEM_W_EN,
  output logic                       B,
  output logic                       S,
  output logic [3:0]                 EXE_CMD,
  output logic [INSTRUCTION_LEN-1:0] Val_Rn,
  output logic [INSTRUCTION_LEN-1:0] Val_Rm,
  output logic                       imm,
  output logic [11:0]                Shift_operand,
  output logic [23:0]                Signed_imm_24,
  output logic [3:0]                 Dest,
  output logic [3:0]                 src1,
  output logic [3:0]                 src2,
  output logic                       Two_src
);

  localparam logic [3:0] OP_MOV = 4'b1101, OP_MVN = 4'b1111, OP_ADD = 4'b0100,
                         OP_ADC = 4'b0101, OP_SUB = 4'b0010, OP_SBC = 4'b0110,
                         OP_AND = 4'b0000, OP_ORR = 4'b1100, OP_EOR = 4'b0001,
                         OP_CMP = 4'b1010, OP_TST = 4'b1000;

  logic [3:0] cond, opcode, rd, rm;
  logic [1:0] mode;
  logic       i_bit, s_bit;

  assign cond          = Instruction[31:28];
  assign mode          = Instruction[27:26];
  assign i_bit         = Instruction[25];
  assign opcode        = Instruction[24:21];
  assign s_bit         = Instruction[20];
  assign src1          = Instruction[19:16];
  assign rd            = Instruction[15:12];
  assign rm            = Instruction[3:0];
  assign Shift_operand = Instruction[11:0];
  assign Signed_imm_24 = Instruction[23:0];
  assign imm           = i_bit;
  assign Dest          = rd;
  assign PC            = PC_in;

  // raw (ungated) control decode
  logic [3:0] cmd_d;
  logic       wb_d, mr_d, mw_d, b_d, s_d, dp_ok;

  // control decode from mode/opcode/S
  always_comb begin
    cmd_d = 4'b0000;
    wb_d  = 1'b0;
    mr_d  = 1'b0;
    mw_d  = 1'b0;
    b_d   = 1'b0;
    s_d   = 1'b0;
    dp_ok = 1'b1;
    case (mode)
      2'b00: begin
        case (opcode)
          OP_MOV:  cmd_d = 4'b0001;
          OP_MVN:  cmd_d = 4'b1001;
          OP_ADD:  cmd_d = 4'b0010;
          OP_ADC:  cmd_d = 4'b0011;
          OP_SUB:  cmd_d = 4'b0100;
          OP_SBC:  cmd_d = 4'b0101;
          OP_AND:  cmd_d = 4'b0110;
          OP_ORR:  cmd_d = 4'b0111;
          OP_EOR:  cmd_d = 4'b1000;
          OP_CMP:  cmd_d = 4'b0100;
          OP_TST:  cmd_d = 4'b0110;
          default: dp_ok = 1'b0;
        endcase
        if (dp_ok) begin
          wb_d = (opcode != OP_CMP) && (opcode != OP_TST);
          s_d  = s_bit;
        end
      end
      2'b01: begin
        // Memory ops are told apart by S (load/store) alone; the opcode field
        // carries addressing bits in encoded loads/stores (e.g. 1100 = P,U set).
        cmd_d = 4'b0010;
        if (s_bit) begin
          mr_d = 1'b1;
          wb_d = 1'b1;
          s_d  = 1'b1;
        end else begin
          mw_d = 1'b1;
        end
      end
      2'b10:   b_d = 1'b1;
      default: ;
    endcase
  end

  // condition evaluation against {N,Z,C,V}
  logic n_f, z_f, c_f, v_f, cond_ok;
  assign {n_f, z_f, c_f, v_f} = SR;

  always_comb begin
    case (cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = ~z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = ~c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = ~n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = ~v_f;
      4'b1000: cond_ok = c_f & ~z_f;
      4'b1001: cond_ok = ~c_f | z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = ~z_f & (n_f == v_f);
      4'b1101: cond_ok = z_f | (n_f != v_f);
      default: cond_ok = 1'b1;
    endcase
  end

  // bubble: failed condition or stall kills all side-effecting controls
  logic kill;
  assign kill     = hazard | ~cond_ok;
  assign WB_EN    = wb_d & ~kill;
  assign MEM_R_EN = mr_d & ~kill;
  assign MEM_W_EN = mw_d & ~kill;
  assign B        = b_d  & ~kill;
  assign S        = s_d  & ~kill;
  assign EXE_CMD  = kill ? 4'b0000 : cmd_d;

  // source info uses the raw decode so it is a pure field of the instruction
  assign src2    = mw_d ? rd : rm;
  assign Two_src = ~i_bit | mw_d;

  // register file
  logic [INSTRUCTION_LEN-1:0] regs [REG_COUNT];

  // async reset to index values; index 15 writes fall through unmatched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= INSTRUCTION_LEN'(i);
    end else if (WB_WB_EN) begin
      for (int i = 0; i < REG_COUNT; i++)
        if (WB_Dest == 4'(i)) regs[i] <= WB_Value;
    end
  end

  // reads with same-cycle write-back bypass (suppressed while in reset)
  logic byp_ok;
  assign byp_ok = WB_WB_EN & ~rst & (WB_Dest != 4'hF);

  always_comb begin
    Val_Rn = '0;
    Val_Rm = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (src1 == 4'(i)) Val_Rn = regs[i];
      if (src2 == 4'(i)) Val_Rm = regs[i];
    end
    if (byp_ok && WB_Dest == src1) Val_Rn = WB_Value;
    if (byp_ok && WB_Dest == src2) Val_Rm = WB_Value;
  end

endmodule
